// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional build macro: FETCH_PERF_CNT_EN (adds fetch_cnt / wait_cnt outputs).
package inst_fetch_unit_pkg;

   localparam int          ADDR_BUS       = 32;
   localparam int          DATA_BUS       = 32;
   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;
   localparam int          PC_INC         = 4;

   // FETCH: a request is (or is about to be) on the memory port.
   // HOLD:  an instruction arrived during a stall and sits in the hold buffer.
   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_HOLD  = 1'b1
   } fetch_state_e;

   // Debug view of the control state, for checkers and waveforms.
   typedef struct packed {
      fetch_state_e state;
      logic         discard;
      logic         hold_valid;
   } fetch_dbg_t;

   // Saturating 32-bit increment used by the performance counters.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction memory port of the fetch stage.
// Optional build macro: FETCH_PERF_CNT_EN (no effect on this file).
//
// Handshake: imem_req=1 opens a request for imem_addr. While the request is
// open, imem_req and imem_addr stay stable; the request is never withdrawn.
// The cycle in which imem_ack=1 completes it, and imem_rdata is valid only in
// that cycle. At most one request is open at any time.
interface inst_fetch_unit_if
   import inst_fetch_unit_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_BUS,
   parameter int ADDR_WIDTH = ADDR_BUS
) ();

   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_ack;
   logic [DATA_WIDTH-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/inst_fetch_unit_fetch_hold_buffer.sv
// One-entry {pc, inst, valid} buffer that parks an instruction received while
// the decode boundary is stalled. Priority: clear > load > pop.
// Optional build macro: FETCH_PERF_CNT_EN (no effect on this file).
module fetch_hold_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  pop,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] load_pc,
   input  logic [DATA_WIDTH-1:0] load_inst,
   output logic                  valid,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] inst
);

   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] inst_q, inst_d;

   // Next-entry selection.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = load_pc;
         inst_d  = load_inst;
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   // Entry registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end

   assign valid = valid_q;
   assign pc    = pc_q;
   assign inst  = inst_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to instruction memory over a
// req/ack port and presents pc/inst/bubble to the fetch-to-decode register.
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_cnt and wait_cnt outputs.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = DATA_BUS,
   parameter int                    ADDR_WIDTH = ADDR_BUS,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC),
   parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(DEF_EXC_VECTOR)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic                  global_flush,
   inst_fetch_unit_if.master     imem,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] inst_out,
   output logic                  bubble_out,
   output fetch_dbg_t            dbg
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           fetch_cnt,
   output logic [31:0]           wait_cnt
`endif
);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  req_q, req_d;
   logic                  discard_q, discard_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] inst_q, inst_d;
   logic                  bubble_q, bubble_d;

   logic                  ack_v;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_raw;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  hb_load, hb_pop, hb_clear, hb_valid;
   logic [ADDR_WIDTH-1:0] hb_pc;
   logic [DATA_WIDTH-1:0] hb_inst;

   // An ack only counts while our own request is open.
   assign ack_v        = imem.imem_ack & req_q;
   assign redirect     = global_flush | branch_taken;
   assign redirect_raw = global_flush ? EXC_VECTOR : branch_target;
   assign redirect_pc  = {redirect_raw[ADDR_WIDTH-1:2], 2'b00};

   // Fetch control: redirect first, then draining the hold buffer, then acks.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      bubble_d   = bubble_q;
      hb_load    = 1'b0;
      hb_pop     = 1'b0;
      hb_clear   = 1'b0;
      if (redirect) begin
         // An ack in this very cycle is simply dropped; without one, the
         // open request's answer is still coming and must be thrown away.
         fetch_pc_d = redirect_pc;
         hb_clear   = 1'b1;
         bubble_d   = 1'b1;
         state_d    = ST_FETCH;
         discard_d  = req_q & ~imem.imem_ack;
      end else if (state_q == ST_HOLD) begin
         if (!stall) begin
            pc_d     = hb_pc;
            inst_d   = hb_inst;
            bubble_d = 1'b0;
            hb_pop   = 1'b1;
            state_d  = ST_FETCH;
         end
      end else if (ack_v) begin
         if (discard_q) begin
            discard_d = 1'b0;
         end else if (stall) begin
            hb_load    = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_INC);
            state_d    = ST_HOLD;
         end else begin
            pc_d       = fetch_pc_q;
            inst_d     = imem.imem_rdata;
            bubble_d   = 1'b0;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_INC);
         end
      end else if (!stall) begin
         bubble_d = 1'b1;
      end
      // The request port is registered; while a stale request is still open
      // its address must not move, so the new target waits in fetch_pc.
      req_d  = (state_d == ST_FETCH);
      addr_d = discard_d ? addr_q : fetch_pc_d;
   end

   // State, PC, request port and decode-boundary output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         discard_q  <= 1'b0;
         pc_q       <= '0;
         inst_q     <= '0;
         bubble_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         discard_q  <= discard_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         bubble_q   <= bubble_d;
      end
   end

   fetch_hold_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_hold (
      .clk      (clk),
      .rst      (rst),
      .load     (hb_load),
      .pop      (hb_pop),
      .clear    (hb_clear),
      .load_pc  (fetch_pc_q),
      .load_inst(imem.imem_rdata),
      .valid    (hb_valid),
      .pc       (hb_pc),
      .inst     (hb_inst)
   );

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign pc_out         = pc_q;
   assign inst_out       = inst_q;
   assign bubble_out     = bubble_q;
   assign dbg            = '{state: state_q, discard: discard_q, hold_valid: hb_valid};

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] wait_cnt_q, wait_cnt_d;
   logic        deliver;

   // A delivery is any edge that loads a fresh valid instruction.
   assign deliver = ~redirect &
                    (((state_q == ST_HOLD) & ~stall) |
                     ((state_q == ST_FETCH) & ack_v & ~discard_q & ~stall));

   // Saturating counts of deliveries and of memory wait cycles.
   always_comb begin
      fetch_cnt_d = deliver ? sat_inc32(fetch_cnt_q) : fetch_cnt_q;
      wait_cnt_d  = (req_q & ~imem.imem_ack) ? sat_inc32(wait_cnt_q) : wait_cnt_q;
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign wait_cnt  = wait_cnt_q;
`endif

endmodule
